// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: one outstanding request to instruction memory and one
// instruction in flight. Optional alignment checking is enabled by IFU_ALIGN_CHECK_EN.
module inst_fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst_n,

    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    input  logic              imem_rsp_err,

    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,

    input  logic              npc_valid,
    input  logic [ADDR_W-1:0] npc,

    output logic              fetch_err,
    output logic [31:0]       fetch_cnt
);

    typedef enum logic [2:0] {
        S_REQ  = 3'd0,
        S_RSP  = 3'd1,
        S_OUT  = 3'd2,
        S_WAIT = 3'd3,
        S_HALT = 3'd4
    } state_e;

`ifdef IFU_ALIGN_CHECK_EN
    localparam state_e RESET_STATE = (RESET_PC[1:0] != 2'b00) ? S_HALT : S_REQ;
`else
    localparam state_e RESET_STATE = S_REQ;
`endif

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic [31:0]       cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RESET_STATE;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            inst_pc_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            S_REQ: begin
                if (imem_req_ready) begin
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                // Responses arriving in any other state are stray and dropped.
                if (imem_rsp_valid) begin
                    if (imem_rsp_err) begin
                        state_d = S_HALT;
                    end else begin
                        inst_d    = imem_rsp_data;
                        inst_pc_d = pc_q;
                        state_d   = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (inst_ready) begin
                    cnt_d   = cnt_q + 32'd1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // npc is only honoured here, so a commit coincident with the
                // decode handshake is ignored by construction.
                if (npc_valid) begin
                    pc_d = npc;
`ifdef IFU_ALIGN_CHECK_EN
                    if (npc[1:0] != 2'b00) begin
                        state_d = S_HALT;
                    end else begin
                        state_d = S_REQ;
                    end
`else
                    state_d = S_REQ;
`endif
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    // rst_n gates the request so outputs read zero while reset is held, yet the
    // first request appears in the very first cycle after release.
    assign imem_req_valid = rst_n && (state_q == S_REQ);
    assign imem_addr      = imem_req_valid ? pc_q : '0;
    assign inst_valid     = (state_q == S_OUT);
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign fetch_err      = rst_n && (state_q == S_HALT);
    assign fetch_cnt      = cnt_q;

endmodule
